// File: rtl/rx_beam_split.sv
// rx_beam_split: receive-side beam separator.
// Rotates one composite I/Q stream by two independent complex weights,
// (I + jQ) * (cos_k + j*sin_k), and saturates each result to DW bits.
// Three register stages (capture, multiply, sum/saturate/output) share one
// valid/ready advance. Weights are double-buffered: shadow set written by
// wt_wr, active set loaded by wt_commit, and each sample carries a snapshot
// of the active set taken when it enters stage 1.
// Optional build macro RX_BEAM_SAT_FLAG_EN adds sticky per-channel clip
// flags on output port sat_flags (order i_1, q_1, i_2, q_2).

module rx_beam_split #(
  parameter int DW = 15,
  parameter int WW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_i,
  input  logic [DW-1:0] in_q,
  input  logic          wt_wr,
  input  logic [1:0]    wt_sel,
  input  logic [WW-1:0] wt_data,
  input  logic          wt_commit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_i_1,
  output logic [DW-1:0] out_q_1,
  output logic [DW-1:0] out_i_2,
  output logic [DW-1:0] out_q_2
`ifdef RX_BEAM_SAT_FLAG_EN
  ,
  output logic [3:0]    sat_flags
`endif
);

  // Product and sum widths: a product never overflows PW bits, and the sum
  // of two products never overflows SW bits.
  localparam int PW = DW + WW;
  localparam int SW = DW + WW + 1;

  // Largest / smallest sum that still fits in DW signed bits.
  localparam logic signed [SW-1:0] SUM_MAX = {{(WW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {{(WW + 2){1'b1}}, {(DW - 1){1'b0}}};

  // Clipped output codes.
  localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW - 1){1'b1}}};
  localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW - 1){1'b0}}};

  // Weight slot indices inside the packed weight sets.
  localparam int W_COS1 = 0;
  localparam int W_SIN1 = 1;
  localparam int W_COS2 = 2;
  localparam int W_SIN2 = 3;

  // Signed sample-by-weight product, both operands sign-extended to PW bits
  // so the low PW bits of the product are exact.
  function automatic logic signed [PW-1:0] smul(input logic [DW-1:0] a,
                                                input logic [WW-1:0] b);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    ax = {{WW{a[DW-1]}}, a};
    bx = {{DW{b[WW-1]}}, b};
    return ax * bx;
  endfunction

  // Sign-extend a product by one bit for the add/subtract stage.
  function automatic logic signed [SW-1:0] sext(input logic [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  // Clamp a sum to the DW-bit signed range.
  function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] x);
    logic [DW-1:0] r;
    if (x > SUM_MAX) begin
      r = OUT_MAX;
    end else if (x < SUM_MIN) begin
      r = OUT_MIN;
    end else begin
      r = x[DW-1:0];
    end
    return r;
  endfunction

`ifdef RX_BEAM_SAT_FLAG_EN
  // True when a sum falls outside the DW-bit signed range.
  function automatic logic is_clip(input logic signed [SW-1:0] x);
    logic r;
    if ((x > SUM_MAX) || (x < SUM_MIN)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------
  // Weights
  // ---------------------------------------------------------------------
  logic [3:0][WW-1:0] shadow_r;
  logic [3:0][WW-1:0] active_r;
  logic [3:0][WW-1:0] shadow_nxt_s;

  // Next shadow set; also what a same-cycle commit loads (write-through).
  always_comb begin
    shadow_nxt_s = shadow_r;
    if (wt_wr) begin
      shadow_nxt_s[wt_sel] = wt_data;
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // Shadow and active weight registers, updated independent of stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= '0;
      active_r <= '0;
    end else begin
      shadow_r <= shadow_nxt_s;
      if (wt_commit) begin
        active_r <= shadow_nxt_s;
      end else begin
        active_r <= active_r;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------
  logic adv_s;
  logic s1_valid_r;
  logic s2_valid_r;
  logic s3_valid_r;

  // Whole pipeline moves together whenever the output register can drain.
  assign adv_s    = ~s3_valid_r | out_ready;
  assign in_ready = adv_s;

  // ---------------------------------------------------------------------
  // Stage 1: capture sample plus weight snapshot
  // ---------------------------------------------------------------------
  logic [DW-1:0]      s1_i_r;
  logic [DW-1:0]      s1_q_r;
  logic [3:0][WW-1:0] s1_w_r;

  // Register the incoming sample with the weights it will be rotated by.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_i_r     <= '0;
      s1_q_r     <= '0;
      s1_w_r     <= '0;
    end else if (adv_s) begin
      s1_valid_r <= in_valid;
      s1_i_r     <= in_i;
      s1_q_r     <= in_q;
      s1_w_r     <= active_r;
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_i_r     <= s1_i_r;
      s1_q_r     <= s1_q_r;
      s1_w_r     <= s1_w_r;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: eight signed products
  // ---------------------------------------------------------------------
  logic [PW-1:0] s2_ic1_r;
  logic [PW-1:0] s2_is1_r;
  logic [PW-1:0] s2_qc1_r;
  logic [PW-1:0] s2_qs1_r;
  logic [PW-1:0] s2_ic2_r;
  logic [PW-1:0] s2_is2_r;
  logic [PW-1:0] s2_qc2_r;
  logic [PW-1:0] s2_qs2_r;

  // Multiply the captured sample by each cos/sin of both beams.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_ic1_r   <= '0;
      s2_is1_r   <= '0;
      s2_qc1_r   <= '0;
      s2_qs1_r   <= '0;
      s2_ic2_r   <= '0;
      s2_is2_r   <= '0;
      s2_qc2_r   <= '0;
      s2_qs2_r   <= '0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_ic1_r   <= smul(s1_i_r, s1_w_r[W_COS1]);
      s2_is1_r   <= smul(s1_i_r, s1_w_r[W_SIN1]);
      s2_qc1_r   <= smul(s1_q_r, s1_w_r[W_COS1]);
      s2_qs1_r   <= smul(s1_q_r, s1_w_r[W_SIN1]);
      s2_ic2_r   <= smul(s1_i_r, s1_w_r[W_COS2]);
      s2_is2_r   <= smul(s1_i_r, s1_w_r[W_SIN2]);
      s2_qc2_r   <= smul(s1_q_r, s1_w_r[W_COS2]);
      s2_qs2_r   <= smul(s1_q_r, s1_w_r[W_SIN2]);
    end else begin
      s2_valid_r <= s2_valid_r;
      s2_ic1_r   <= s2_ic1_r;
      s2_is1_r   <= s2_is1_r;
      s2_qc1_r   <= s2_qc1_r;
      s2_qs1_r   <= s2_qs1_r;
      s2_ic2_r   <= s2_ic2_r;
      s2_is2_r   <= s2_is2_r;
      s2_qc2_r   <= s2_qc2_r;
      s2_qs2_r   <= s2_qs2_r;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: sum, saturate, output register
  // ---------------------------------------------------------------------
  logic signed [SW-1:0] bi1_s;
  logic signed [SW-1:0] bq1_s;
  logic signed [SW-1:0] bi2_s;
  logic signed [SW-1:0] bq2_s;
  logic [DW-1:0]        nxt_i1_s;
  logic [DW-1:0]        nxt_q1_s;
  logic [DW-1:0]        nxt_i2_s;
  logic [DW-1:0]        nxt_q2_s;
  logic [DW-1:0]        s3_i1_r;
  logic [DW-1:0]        s3_q1_r;
  logic [DW-1:0]        s3_i2_r;
  logic [DW-1:0]        s3_q2_r;

  // Complex rotation sums: bi = i*cos - q*sin, bq = q*cos + i*sin.
  always_comb begin
    bi1_s = sext(s2_ic1_r) - sext(s2_qs1_r);
    bq1_s = sext(s2_qc1_r) + sext(s2_is1_r);
    bi2_s = sext(s2_ic2_r) - sext(s2_qs2_r);
    bq2_s = sext(s2_qc2_r) + sext(s2_is2_r);
  end

  // Saturated next outputs; bubbles load zeros so no stale data is shown.
  always_comb begin
    nxt_i1_s = '0;
    nxt_q1_s = '0;
    nxt_i2_s = '0;
    nxt_q2_s = '0;
    if (s2_valid_r) begin
      nxt_i1_s = sat(bi1_s);
      nxt_q1_s = sat(bq1_s);
      nxt_i2_s = sat(bi2_s);
      nxt_q2_s = sat(bq2_s);
    end else begin
      nxt_i1_s = '0;
      nxt_q1_s = '0;
      nxt_i2_s = '0;
      nxt_q2_s = '0;
    end
  end

  // Output register; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid_r <= 1'b0;
      s3_i1_r    <= '0;
      s3_q1_r    <= '0;
      s3_i2_r    <= '0;
      s3_q2_r    <= '0;
    end else if (adv_s) begin
      s3_valid_r <= s2_valid_r;
      s3_i1_r    <= nxt_i1_s;
      s3_q1_r    <= nxt_q1_s;
      s3_i2_r    <= nxt_i2_s;
      s3_q2_r    <= nxt_q2_s;
    end else begin
      s3_valid_r <= s3_valid_r;
      s3_i1_r    <= s3_i1_r;
      s3_q1_r    <= s3_q1_r;
      s3_i2_r    <= s3_i2_r;
      s3_q2_r    <= s3_q2_r;
    end
  end

  assign out_valid = s3_valid_r;
  assign out_i_1   = s3_i1_r;
  assign out_q_1   = s3_q1_r;
  assign out_i_2   = s3_i2_r;
  assign out_q_2   = s3_q2_r;

`ifdef RX_BEAM_SAT_FLAG_EN
  // ---------------------------------------------------------------------
  // Sticky saturation flags
  // ---------------------------------------------------------------------
  logic [3:0] s3_clip_r;
  logic [3:0] clip_nxt_s;
  logic [3:0] flag_set_s;
  logic [3:0] flag_nxt_s;
  logic [3:0] sat_flags_r;

  // Per-channel clip indication travelling with the stage 3 sample.
  always_comb begin
    clip_nxt_s = 4'b0000;
    if (s2_valid_r) begin
      clip_nxt_s = {is_clip(bq2_s), is_clip(bi2_s), is_clip(bq1_s), is_clip(bi1_s)};
    end else begin
      clip_nxt_s = 4'b0000;
    end
  end

  // Clip bits follow the output register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_clip_r <= 4'b0000;
    end else if (adv_s) begin
      s3_clip_r <= clip_nxt_s;
    end else begin
      s3_clip_r <= s3_clip_r;
    end
  end

  // Flags set on a transferred clipped sample; commit clears, set wins.
  always_comb begin
    flag_set_s = 4'b0000;
    flag_nxt_s = sat_flags_r;
    if (s3_valid_r && out_ready) begin
      flag_set_s = s3_clip_r;
    end else begin
      flag_set_s = 4'b0000;
    end
    if (wt_commit) begin
      flag_nxt_s = flag_set_s;
    end else begin
      flag_nxt_s = sat_flags_r | flag_set_s;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flags_r <= 4'b0000;
    end else begin
      sat_flags_r <= flag_nxt_s;
    end
  end

  assign sat_flags = sat_flags_r;
`endif

endmodule

// File: tb/tb_rx_beam_split.sv
// Directed self-checking bench for rx_beam_split (DW=15, WW=5).
module tb_rx_beam_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_i;
  logic [14:0] in_q;
  logic        wt_wr;
  logic [1:0]  wt_sel;
  logic [4:0]  wt_data;
  logic        wt_commit;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_i_1;
  logic [14:0] out_q_1;
  logic [14:0] out_i_2;
  logic [14:0] out_q_2;
`ifdef RX_BEAM_SAT_FLAG_EN
  logic [3:0]  sat_flags;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_beam_split dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_i      (in_i),
    .in_q      (in_q),
    .wt_wr     (wt_wr),
    .wt_sel    (wt_sel),
    .wt_data   (wt_data),
    .wt_commit (wt_commit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i_1   (out_i_1),
    .out_q_1   (out_q_1),
    .out_i_2   (out_i_2),
    .out_q_2   (out_q_2)
`ifdef RX_BEAM_SAT_FLAG_EN
    ,
    .sat_flags (sat_flags)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_i1, input logic [31:0] e_q1,
                         input logic [31:0] e_i2, input logic [31:0] e_q2);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_i1"}, {17'd0, out_i_1}, e_i1);
    chk({tag, "_q1"}, {17'd0, out_q_1}, e_q1);
    chk({tag, "_i2"}, {17'd0, out_i_2}, e_i2);
    chk({tag, "_q2"}, {17'd0, out_q_2}, e_q2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one shadow weight, optionally committing in the same cycle.
  task automatic wt_write(input logic [1:0] sel, input logic [4:0] data, input logic commit);
    wt_wr     = 1'b1;
    wt_sel    = sel;
    wt_data   = data;
    wt_commit = commit;
    tick();
    wt_wr     = 1'b0;
    wt_commit = 1'b0;
  endtask

  int          sent;
  int          rcv;
  logic        acc;
  logic        xfer;
  logic        prev_stall;
  logic [14:0] held;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_i      = 15'd0;
    in_q      = 15'd0;
    wt_wr     = 1'b0;
    wt_sel    = 2'd0;
    wt_data   = 5'd0;
    wt_commit = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_i_1", {17'd0, out_i_1}, 32'd0);
    chk("rst_out_q_2", {17'd0, out_q_2}, 32'd0);
`ifdef RX_BEAM_SAT_FLAG_EN
    chk("rst_flags", {28'd0, sat_flags}, 32'd0);
`endif
    out_ready = 1'b1;

    // Identity-like rotation: cos_1=8 written and committed together
    wt_write(2'd0, 5'd8, 1'b1);
    in_valid = 1'b1; in_i = 15'd100; in_q = 15'd50;
    tick();
    in_valid = 1'b0;
    tick();
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    chk_out("basic", 32'd800, 32'd400, 32'd0, 32'd0);

    // Sine path: sin_2=4, i=10 q=3 -> beam2 = (-12, 40)
    wt_write(2'd3, 5'd4, 1'b1);
    in_valid = 1'b1; in_i = 15'd10; in_q = 15'd3;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk_out("sine", 32'd80, 32'd24, 32'h7FF4, 32'd40);

    // Saturation: cos_1=15, full-scale positive then negative
    wt_write(2'd0, 5'd15, 1'b1);
    in_valid = 1'b1; in_i = 15'h3FFF; in_q = 15'd0;
    tick();
    in_i = 15'h4000;
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("sat_pos", 32'h3FFF, 32'd0, 32'd0, 32'h3FFF);
    tick();
    chk_out("sat_neg", 32'h4000, 32'd0, 32'd0, 32'h4000);
    tick();
    chk("sat_drained", {31'd0, out_valid}, 32'd0);
`ifdef RX_BEAM_SAT_FLAG_EN
    chk("sat_flags", {28'd0, sat_flags}, 32'h9);
`endif

    // Backpressure: cos_1=1, stream 1..10, out_ready low for cycles 4..7
    wt_write(2'd0, 5'd1, 1'b1);
`ifdef RX_BEAM_SAT_FLAG_EN
    chk("commit_clears_flags", {28'd0, sat_flags}, 32'd0);
`endif
    sent = 0;
    rcv = 0;
    prev_stall = 1'b0;
    held = 15'd0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c >= 4 && c <= 7) ? 1'b0 : 1'b1;
      in_valid  = (sent < 10) ? 1'b1 : 1'b0;
      in_i      = 15'(sent + 1);
      in_q      = 15'd0;
      #1;
      if (prev_stall) begin
        chk("bp_hold", {17'd0, out_i_1}, {17'd0, held});
      end
      prev_stall = out_valid & ~out_ready;
      held = out_i_1;
      if (out_valid && !out_ready) begin
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      end
      acc  = in_valid & in_ready;
      xfer = out_valid & out_ready;
      if (xfer) begin
        chk("bp_data_i1", {17'd0, out_i_1}, 32'(rcv + 1));
        chk("bp_data_q2", {17'd0, out_q_2}, 32'(4 * (rcv + 1)));
        rcv++;
      end
      tick();
      if (acc) begin
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", 32'(sent), 32'd10);
    chk("bp_rcvd", 32'(rcv), 32'd10);

    // Commit mid-stream: shadow cos_1=2 at c=0, commit at c=2
    in_i = 15'd1;
    in_q = 15'd0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      wt_wr     = (c == 0) ? 1'b1 : 1'b0;
      wt_sel    = 2'd0;
      wt_data   = 5'd2;
      wt_commit = (c == 2) ? 1'b1 : 1'b0;
      tick();
      if (c >= 2) begin
        chk_out("commit", (c - 2 <= 2) ? 32'd1 : 32'd2, 32'd0, 32'd0, 32'd4);
      end
    end
    wt_wr = 1'b0;
    wt_commit = 1'b0;

    // Reset with samples in flight
    in_i = 15'd5;
    in_q = 15'd7;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_out_i_1", {17'd0, out_i_1}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst2_no_stale", {31'd0, out_valid}, 32'd0);
    end
`ifdef RX_BEAM_SAT_FLAG_EN
    chk("rst2_flags", {28'd0, sat_flags}, 32'd0);
`endif
    in_valid = 1'b1; in_i = 15'd100; in_q = 15'd50;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk_out("rst2_zero_wt", 32'd0, 32'd0, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
